execute_muldiv_sequencer: RTL and testbench

//  Iterative RV32M multiply/divide unit beside the execute-stage ALU. Accepts one M-extension op, runs a

---
 rtl/execute_muldiv_sequencer_pkg.sv | 50 +++++
 rtl/execute_muldiv_sequencer_if.sv | 26 ++
 rtl/execute_muldiv_sequencer_iter_core.sv | 56 +++++
 rtl/execute_muldiv_sequencer.sv | 155 +++++++++++++++
 tb/tb_execute_muldiv_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/execute_muldiv_sequencer_pkg.sv
// Shared types for the iterative RV32M multiply/divide sequencer.
// Optional build macro MULDIV_FAST_PATH_EN is consumed by execute_muldiv_sequencer.
package execute_muldiv_sequencer_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned RD_W     = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic alu_src;
    logic mul_div;
  } control_type;

  function automatic logic op_signed_a(input muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_signed_b(input muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_is_rem(input muldiv_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/execute_muldiv_sequencer_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide sequencer.
interface execute_muldiv_sequencer_if #(parameter int unsigned XLEN = 32);
  import execute_muldiv_sequencer_pkg::*;

  logic             start;
  muldiv_op_t       op;
  logic [XLEN-1:0]  operand_a;
  logic [XLEN-1:0]  operand_b;
  logic [RD_W-1:0]  rd_in;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             result_valid;
  logic [XLEN-1:0]  result;
  logic [RD_W-1:0]  rd_out;

  modport master (
    output start, op, operand_a, operand_b, rd_in, flush,
    input  stall, busy, result_valid, result, rd_out
  );

  modport slave (
    input  start, op, operand_a, operand_b, rd_in, flush,
    output stall, busy, result_valid, result, rd_out
  );
endinterface

// File: rtl/execute_muldiv_sequencer_iter_core.sv
// One radix-2 step per cycle: shift-add multiply or restoring divide on magnitudes.
module execute_muldiv_sequencer_iter_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opnd;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  // hi:lo is the running product (mul) or partial remainder:quotient (div)
  always_comb begin
    sum     = {1'b0, hi} + {1'b0, opnd & {XLEN{lo[0]}}};
    shifted = {hi, lo[XLEN-1]};
    trial   = shifted - {1'b0, opnd};
    hi_nxt  = sum[XLEN:1];
    lo_nxt  = {sum[0], lo[XLEN-1:1]};
    if (is_div) begin
      if (!trial[XLEN]) begin
        hi_nxt = trial[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi   <= '0;
      lo   <= '0;
      opnd <= '0;
    end else if (load) begin
      hi   <= '0;
      lo   <= a_mag;
      opnd <= b_mag;
    end else if (step) begin
      hi   <= hi_nxt;
      lo   <= lo_nxt;
    end
  end

endmodule

// File: rtl/execute_muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer that stalls EX until its result is ready.
// Build macro MULDIV_FAST_PATH_EN: special-case operands skip the iteration loop.
module execute_muldiv_sequencer
  import execute_muldiv_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  execute_muldiv_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  muldiv_state_t     state;
  muldiv_state_t     state_nxt;
  logic [CNT_W-1:0]  count;
  muldiv_op_t        op_q;
  logic              neg_q;
  logic              spec_q;
  logic              accept;
  logic              fast;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              special;
  logic [XLEN-1:0]   special_val;
  logic [XLEN-1:0]   hi_nxt;
  logic [XLEN-1:0]   lo_nxt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   post_val;

  assign accept = (state == IDLE) && bus.start && !bus.flush;
  assign a_neg  = op_signed_a(bus.op) && bus.operand_a[XLEN-1];
  assign b_neg  = op_signed_b(bus.op) && bus.operand_b[XLEN-1];
  assign a_mag  = a_neg ? -bus.operand_a : bus.operand_a;
  assign b_mag  = b_neg ? -bus.operand_b : bus.operand_b;

  // Zero operands, divide by zero and signed overflow have fixed answers
  always_comb begin
    special     = 1'b0;
    special_val = '0;
    case (bus.op)
      OP_DIV, OP_DIVU: begin
        if (bus.operand_b == '0) begin
          special     = 1'b1;
          special_val = '1;
        end else if (bus.op == OP_DIV && bus.operand_a == {1'b1, {(XLEN-1){1'b0}}} && (&bus.operand_b)) begin
          special     = 1'b1;
          special_val = bus.operand_a;
        end
      end
      OP_REM, OP_REMU: begin
        if (bus.operand_b == '0) begin
          special     = 1'b1;
          special_val = bus.operand_a;
        end else if (bus.op == OP_REM && bus.operand_a == {1'b1, {(XLEN-1){1'b0}}} && (&bus.operand_b)) begin
          special     = 1'b1;
        end
      end
      default: special = (bus.operand_a == '0) || (bus.operand_b == '0);
    endcase
  end

`ifdef MULDIV_FAST_PATH_EN
  assign fast = special;
`else
  assign fast = 1'b0;
`endif

  execute_muldiv_sequencer_iter_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (state == CALC),
    .is_div (op_is_div(op_q)),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  // Sign fix-up and half/quotient/remainder select on the final step's output
  always_comb begin
    prod = {hi_nxt, lo_nxt};
    if (neg_q) prod = -prod;
    case (op_q)
      OP_MUL:                     post_val = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: post_val = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:            post_val = neg_q ? -lo_nxt : lo_nxt;
      default:                    post_val = neg_q ? -hi_nxt : hi_nxt;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fast ? DONE : CALC;
      CALC:    if (bus.flush) state_nxt = IDLE;
               else if (count == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.stall        = 1'b0;
    bus.busy         = 1'b0;
    bus.result_valid = 1'b0;
    case (state)
      IDLE: bus.stall = bus.start && !bus.flush;
      CALC: begin
        bus.stall = 1'b1;
        bus.busy  = 1'b1;
      end
      DONE: begin
        bus.busy         = 1'b1;
        bus.result_valid = !bus.flush;
      end
      default: ;
    endcase
  end

  // Special answers are loaded at accept and kept; iterated answers land on the last step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      op_q       <= OP_MUL;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      bus.result <= '0;
      bus.rd_out <= '0;
    end else if (accept) begin
      count      <= CNT_W'(XLEN - 1);
      op_q       <= bus.op;
      neg_q      <= op_is_rem(bus.op) ? a_neg : (a_neg ^ b_neg);
      spec_q     <= special;
      bus.result <= special_val;
      bus.rd_out <= bus.rd_in;
    end else if (state == CALC && !bus.flush) begin
      if (count == '0) begin
        if (!spec_q) bus.result <= post_val;
      end else begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_execute_muldiv_sequencer.sv
// Directed bench for execute_muldiv_sequencer; honours MULDIV_FAST_PATH_EN when defined.
module tb_execute_muldiv_sequencer;
  import execute_muldiv_sequencer_pkg::*;

`ifdef MULDIV_FAST_PATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          spec;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  execute_muldiv_sequencer_if #(.XLEN(32)) bus ();

  execute_muldiv_sequencer #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input bit spec);
    return (FAST && spec) ? 1 : 33;
  endfunction

  // Presents one op at the current cycle and waits (bounded) for result_valid
  task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                        output int lat, output logic acc_stall);
    bus.op = op; bus.operand_a = a; bus.operand_b = b; bus.rd_in = rd; bus.start = 1'b1;
    #1 acc_stall = bus.stall;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.result_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    rdo = bus.rd_out;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = OP_MUL;
    bus.operand_a = '0; bus.operand_b = '0; bus.rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b want 0", bus.stall); end
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vectors++;
    if (bus.result_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus.result_valid); end
    vectors++;
    if (bus.result !== 32'h0) begin miscompares++; $display("FAIL reset_result got %h want 0", bus.result); end
    vectors++;
    if (bus.rd_out !== 5'd0) begin miscompares++; $display("FAIL reset_rd got %0d want 0", bus.rd_out); end
    #2 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_timing();
    int lat;
    int stall_lo;
    bus.op = OP_MUL; bus.operand_a = 32'd7; bus.operand_b = 32'hFFFF_FFFD; bus.rd_in = 5'd11;
    bus.start = 1'b1;
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL mul_accept_stall got %b want 1", bus.stall); end
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1; stall_lo = 0;
    while (!bus.result_valid && lat < 60) begin
      if (bus.stall !== 1'b1) stall_lo++;
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (stall_lo != 0) begin miscompares++; $display("FAIL mul_calc_stall low for %0d cycles want 0", stall_lo); end
    vectors++;
    if (lat != 33) begin miscompares++; $display("FAIL mul_latency got %0d want 33", lat); end
    vectors++;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL mul_done_stall got %b want 0", bus.stall); end
    vectors++;
    if (bus.result !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL mul_result got %h want ffffffeb", bus.result); end
    vectors++;
    if (bus.rd_out !== 5'd11) begin miscompares++; $display("FAIL mul_rd got %0d want 11", bus.rd_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_multiply();
    vec_t v[6];
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    logic        acc;
    v[0] = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    v[1] = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    v[2] = '{OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
    v[3] = '{OP_MULHU,  32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 1'b0};
    v[4] = '{OP_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0};
    v[5] = '{OP_MULH,   32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    for (int i = 0; i < 6; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, 5'(i + 1), res, rdo, lat, acc);
      vectors++;
      if (res !== v[i].exp) begin
        miscompares++;
        $display("FAIL mul_vec%0d result got %h want %h", i, res, v[i].exp);
      end
      vectors++;
      if (lat != exp_lat(v[i].spec)) begin
        miscompares++;
        $display("FAIL mul_vec%0d latency got %0d want %0d", i, lat, exp_lat(v[i].spec));
      end
    end
  endtask

  task automatic test_divide();
    vec_t v[12];
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    logic        acc;
    v[0]  = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 1'b0};
    v[1]  = '{OP_REM,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 1'b0};
    v[2]  = '{OP_DIVU, 32'd7,         32'd0,          32'hFFFF_FFFF, 1'b1};
    v[3]  = '{OP_REMU, 32'd7,         32'd0,          32'h0000_0007, 1'b1};
    v[4]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    v[5]  = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    v[6]  = '{OP_DIV,  32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFF, 1'b1};
    v[7]  = '{OP_REM,  32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 1'b1};
    v[8]  = '{OP_DIVU, 32'd100,       32'd7,          32'd14,        1'b0};
    v[9]  = '{OP_REMU, 32'd100,       32'd7,          32'd2,         1'b0};
    v[10] = '{OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
    v[11] = '{OP_REM,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    for (int i = 0; i < 12; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, 5'(i + 16), res, rdo, lat, acc);
      vectors++;
      if (res !== v[i].exp) begin
        miscompares++;
        $display("FAIL div_vec%0d result got %h want %h", i, res, v[i].exp);
      end
      vectors++;
      if (lat != exp_lat(v[i].spec)) begin
        miscompares++;
        $display("FAIL div_vec%0d latency got %0d want %0d", i, lat, exp_lat(v[i].spec));
      end
      vectors++;
      if (rdo !== 5'(i + 16)) begin
        miscompares++;
        $display("FAIL div_vec%0d rd got %0d want %0d", i, rdo, i + 16);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    int          pulses;
    logic        acc;
    // flush in IDLE blocks accept
    bus.op = OP_DIVU; bus.operand_a = 32'd1000; bus.operand_b = 32'd3; bus.rd_in = 5'd4;
    bus.start = 1'b1; bus.flush = 1'b1;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL flush_idle_stall got %b want 0", bus.stall); end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL flush_idle_busy got %b want 0", bus.busy); end
    // accepted now (T); flush at T+10
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    vectors++;
    if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL flush_pre_busy got %b want 1", bus.busy); end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_calc busy=%b stall=%b want 0 0", bus.busy, bus.stall);
    end
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, res, rdo, lat, acc);
    vectors++;
    if (acc !== 1'b1) begin miscompares++; $display("FAIL flush_restart_stall got %b want 1", acc); end
    vectors++;
    if (lat != 33 || res !== 32'hFFFF_FFFE || rdo !== 5'd6) begin
      miscompares++;
      $display("FAIL flush_restart lat=%0d res=%h rd=%0d want 33 fffffffe 6", lat, res, rdo);
    end
    // flush on the final CALC cycle beats counter expiry
    bus.op = OP_MUL; bus.operand_a = 32'd3; bus.operand_b = 32'd5; bus.rd_in = 5'd7;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (31) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    pulses = 0;
    repeat (40) begin
      if (bus.result_valid === 1'b1 || bus.busy === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    vectors++;
    if (pulses != 0) begin miscompares++; $display("FAIL flush_last_calc active cycles got %0d want 0", pulses); end
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.op = OP_MUL; bus.operand_a = 32'd6; bus.operand_b = 32'd7; bus.rd_in = 5'd3;
    bus.start = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (!bus.result_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    vectors++;
    if (lat != 33 || bus.result !== 32'd42 || bus.rd_out !== 5'd3) begin
      miscompares++;
      $display("FAIL b2b_first lat=%0d res=%h rd=%0d want 33 0000002a 3", lat, bus.result, bus.rd_out);
    end
    bus.op = OP_DIVU; bus.operand_a = 32'd100; bus.operand_b = 32'd7; bus.rd_in = 5'd9;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL b2b_done_stall got %b want 0", bus.stall); end
    @(posedge clk); #1;
    vectors++;
    if (bus.stall !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept stall=%b busy=%b want 1 0", bus.stall, bus.busy);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.result_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    vectors++;
    if (lat != 33 || bus.result !== 32'd14 || bus.rd_out !== 5'd9) begin
      miscompares++;
      $display("FAIL b2b_second lat=%0d res=%h rd=%0d want 33 0000000e 9", lat, bus.result, bus.rd_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int active;
    bus.op = OP_MUL; bus.operand_a = 32'd7; bus.operand_b = 32'hFFFF_FFFD; bus.rd_in = 5'd5;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    vectors++;
    if (bus.rd_out !== 5'd5 || bus.stall !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_pre rd=%0d stall=%b want 5 1", bus.rd_out, bus.stall);
    end
    #1 rst = 1'b0;
    #1;
    vectors++;
    if ({bus.stall, bus.busy, bus.result_valid, bus.result, bus.rd_out} !== 40'h0) begin
      miscompares++;
      $display("FAIL areset_outputs stall=%b busy=%b valid=%b res=%h rd=%0d want all 0",
               bus.stall, bus.busy, bus.result_valid, bus.result, bus.rd_out);
    end
    #4 rst = 1'b1;
    @(posedge clk); #1;
    active = 0;
    repeat (40) begin
      if (bus.result_valid === 1'b1 || bus.busy === 1'b1) active++;
      @(posedge clk); #1;
    end
    vectors++;
    if (active != 0) begin miscompares++; $display("FAIL areset_after active cycles got %0d want 0", active); end
  endtask

  initial begin
    test_reset();
    test_mul_timing();
    test_multiply();
    test_divide();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
